// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the ID/EX stage and its forwarding unit.
//   - ALU opcode encodings driven on ALUCtl
//   - default datapath / register-address widths
//   - forwarding source-select encoding
//   - packed bundle of the EX-side control bits
package mips_pkg;

  localparam int DW_DEF   = 32;
  localparam int RW_DEF   = 5;
  localparam int REG_ZERO = 0;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDU = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b1011;
  localparam logic [3:0] ALU_SUBO = 4'b1110;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ex_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: source select for one EX operand.
//   reg_addr                        captured source register of the operand
//   ex_mem_reg_write / ex_mem_rd    producer one stage ahead
//   mem_wb_reg_write / mem_wb_rd    producer two stages ahead
//   sel                             FWD_EXMEM, FWD_MEMWB or FWD_RF
// The younger EX/MEM result wins; $0 is never forwarded.
module fwd_unit
  import mips_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] reg_addr,
  input  logic          ex_mem_reg_write,
  input  logic [RW-1:0] ex_mem_rd,
  input  logic          mem_wb_reg_write,
  input  logic [RW-1:0] mem_wb_rd,
  output logic [1:0]    sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_addr != RW'(REG_ZERO)) begin
      if (ex_mem_reg_write && (ex_mem_rd == reg_addr)) begin
        sel = FWD_EXMEM;
      end else if (mem_wb_reg_write && (mem_wb_rd == reg_addr)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register, EX operand forwarding and
// load-use hazard detection, feeding the ALU.
//   Id*                 decoded instruction fields from ID
//   Flush / Hold        kill the entering instruction / freeze ID/EX
//   ExMem* / MemWb*     downstream results available for forwarding
//   ALUCtl/Shamt/A/B    ALU inputs, one cycle after the Id* fields
//   StoreData           forwarded Rt value for stores
//   ExRd, Ex* controls  captured destination and controls
//   Stall               load-use hazard: freeze PC and IF/ID
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          IdValid,
  input  logic [3:0]    IdALUCtl,
  input  logic [4:0]    IdShamt,
  input  logic [DW-1:0] IdRsData,
  input  logic [DW-1:0] IdRtData,
  input  logic [DW-1:0] IdImm,
  input  logic [RW-1:0] IdRs,
  input  logic [RW-1:0] IdRt,
  input  logic [RW-1:0] IdRd,
  input  logic          IdALUSrc,
  input  logic          IdRegWrite,
  input  logic          IdMemRead,
  input  logic          IdMemWrite,
  input  logic          IdMemToReg,
  input  logic          Flush,
  input  logic          Hold,
  input  logic          ExMemRegWrite,
  input  logic [RW-1:0] ExMemRd,
  input  logic [DW-1:0] ExMemALUOut,
  input  logic          MemWbRegWrite,
  input  logic [RW-1:0] MemWbRd,
  input  logic [DW-1:0] MemWbData,
  output logic [3:0]    ALUCtl,
  output logic [4:0]    Shamt,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [DW-1:0] StoreData,
  output logic [RW-1:0] ExRd,
  output logic          ExValid,
  output logic          ExRegWrite,
  output logic          ExMemRead,
  output logic          ExMemWrite,
  output logic          ExMemToReg,
  output logic          Stall
);

  function automatic logic [DW-1:0] fwd_pick(input logic [1:0]    sel,
                                             input logic [DW-1:0] rf,
                                             input logic [DW-1:0] ex_mem,
                                             input logic [DW-1:0] mem_wb);
    case (sel)
      FWD_EXMEM: return ex_mem;
      FWD_MEMWB: return mem_wb;
      default:   return rf;
    endcase
  endfunction

  ex_ctrl_t      ctrl_d, ctrl_q;
  logic [3:0]    alu_ctl_d, alu_ctl_q;
  logic [4:0]    shamt_d, shamt_q;
  logic [DW-1:0] rs_data_d, rs_data_q;
  logic [DW-1:0] rt_data_d, rt_data_q;
  logic [DW-1:0] imm_d, imm_q;
  logic [RW-1:0] rs_d, rs_q;
  logic [RW-1:0] rt_d, rt_q;
  logic [RW-1:0] rd_d, rd_q;

  logic          load_use;
  logic [1:0]    rs_sel, rt_sel;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // Rt is a true source only for register-register ops and for stores
  // (store data); an immediate-form op ignores it.
  always_comb begin
    load_use = ctrl_q.valid && ctrl_q.mem_read && IdValid &&
               (rd_q != RW'(REG_ZERO)) &&
               ((rd_q == IdRs) ||
                ((rd_q == IdRt) && (!IdALUSrc || IdMemWrite)));
  end

  // While Hold is up IF/ID is already frozen, so no separate stall.
  assign Stall = load_use && !Hold;

  // ---- ID -> EX boundary ----
  always_comb begin
    ctrl_d    = ctrl_q;
    alu_ctl_d = alu_ctl_q;
    shamt_d   = shamt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (Flush || Stall) begin
      ctrl_d    = '0;
      alu_ctl_d = '0;
      shamt_d   = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
    end else if (!Hold) begin
      ctrl_d.valid      = IdValid;
      ctrl_d.reg_write  = IdRegWrite & IdValid;
      ctrl_d.mem_read   = IdMemRead  & IdValid;
      ctrl_d.mem_write  = IdMemWrite & IdValid;
      ctrl_d.mem_to_reg = IdMemToReg & IdValid;
      ctrl_d.alu_src    = IdALUSrc   & IdValid;
      alu_ctl_d = IdALUCtl;
      shamt_d   = IdShamt;
      rs_data_d = IdRsData;
      rt_data_d = IdRtData;
      imm_d     = IdImm;
      rs_d      = IdRs;
      rt_d      = IdRt;
      rd_d      = IdRd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      alu_ctl_q <= '0;
      shamt_q   <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      alu_ctl_q <= alu_ctl_d;
      shamt_q   <= shamt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  // ---- EX operand resolution ----
  fwd_unit #(.RW(RW)) u_fwd_rs (
    .reg_addr         (rs_q),
    .ex_mem_reg_write (ExMemRegWrite),
    .ex_mem_rd        (ExMemRd),
    .mem_wb_reg_write (MemWbRegWrite),
    .mem_wb_rd        (MemWbRd),
    .sel              (rs_sel)
  );

  fwd_unit #(.RW(RW)) u_fwd_rt (
    .reg_addr         (rt_q),
    .ex_mem_reg_write (ExMemRegWrite),
    .ex_mem_rd        (ExMemRd),
    .mem_wb_reg_write (MemWbRegWrite),
    .mem_wb_rd        (MemWbRd),
    .sel              (rt_sel)
  );

  assign fwd_rs = fwd_pick(rs_sel, rs_data_q, ExMemALUOut, MemWbData);
  assign fwd_rt = fwd_pick(rt_sel, rt_data_q, ExMemALUOut, MemWbData);

  assign A          = fwd_rs;
  assign B          = ctrl_q.alu_src ? imm_q : fwd_rt;
  assign StoreData  = fwd_rt;
  assign ALUCtl     = alu_ctl_q;
  assign Shamt      = shamt_q;
  assign ExRd       = rd_q;
  assign ExValid    = ctrl_q.valid;
  assign ExRegWrite = ctrl_q.reg_write;
  assign ExMemRead  = ctrl_q.mem_read;
  assign ExMemWrite = ctrl_q.mem_write;
  assign ExMemToReg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: bench for id_ex_stage. Directed table of pipeline
// scenarios with hand-derived expected outputs, a randomized run checked
// against a behavioural model of the EX slot, and an async-reset-mid-stall
// sequence.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        IdValid, IdALUSrc, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg;
  logic [3:0]  IdALUCtl;
  logic [4:0]  IdShamt;
  logic [31:0] IdRsData, IdRtData, IdImm;
  logic [4:0]  IdRs, IdRt, IdRd;
  logic        Flush, Hold;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemRd, MemWbRd;
  logic [31:0] ExMemALUOut, MemWbData;
  logic [3:0]  ALUCtl;
  logic [4:0]  Shamt;
  logic [31:0] A, B, StoreData;
  logic [4:0]  ExRd;
  logic        ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, Stall;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .IdValid(IdValid), .IdALUCtl(IdALUCtl), .IdShamt(IdShamt),
    .IdRsData(IdRsData), .IdRtData(IdRtData), .IdImm(IdImm),
    .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
    .IdALUSrc(IdALUSrc), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdMemWrite(IdMemWrite), .IdMemToReg(IdMemToReg),
    .Flush(Flush), .Hold(Hold),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemALUOut(ExMemALUOut),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
    .ALUCtl(ALUCtl), .Shamt(Shamt), .A(A), .B(B), .StoreData(StoreData),
    .ExRd(ExRd), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg),
    .Stall(Stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        IdValid;
    logic [3:0]  IdALUCtl;
    logic [4:0]  IdShamt;
    logic [31:0] IdRsData, IdRtData, IdImm;
    logic [4:0]  IdRs, IdRt, IdRd;
    logic        IdALUSrc, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg;
    logic        Flush, Hold;
    logic        ExMemRegWrite;
    logic [4:0]  ExMemRd;
    logic [31:0] ExMemALUOut;
    logic        MemWbRegWrite;
    logic [4:0]  MemWbRd;
    logic [31:0] MemWbData;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        ev, erw, emw;
    logic [3:0]  ealu;
    logic [31:0] ea, eb, esd;
    logic        est;
  } row_t;

  // What the EX slot holds, in instruction terms.
  typedef struct packed {
    logic        valid, rw, mr, mw, m2r, src;
    logic [3:0]  alu;
    logic [4:0]  shamt;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
  } slot_t;

  int    checks = 0;
  int    errors = 0;
  row_t  tbl[22];
  slot_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic in_t rtype(input int alu, input int rs, input int rsd,
                                input int rt, input int rtd, input int rd);
    in_t v;
    v = '0;
    v.IdValid = 1'b1; v.IdRegWrite = 1'b1; v.IdALUCtl = 4'(alu);
    v.IdRs = 5'(rs); v.IdRsData = 32'(rsd);
    v.IdRt = 5'(rt); v.IdRtData = 32'(rtd); v.IdRd = 5'(rd);
    return v;
  endfunction

  function automatic in_t lw(input int rs, input int rsd, input int imm, input int rd);
    in_t v;
    v = '0;
    v.IdValid = 1'b1; v.IdRegWrite = 1'b1; v.IdMemRead = 1'b1; v.IdMemToReg = 1'b1;
    v.IdALUSrc = 1'b1; v.IdALUCtl = ALU_ADD;
    v.IdRs = 5'(rs); v.IdRsData = 32'(rsd); v.IdImm = 32'(imm); v.IdRd = 5'(rd);
    return v;
  endfunction

  function automatic in_t sw(input int rs, input int rsd, input int rt, input int rtd,
                             input int imm);
    in_t v;
    v = '0;
    v.IdValid = 1'b1; v.IdMemWrite = 1'b1; v.IdALUSrc = 1'b1; v.IdALUCtl = ALU_ADD;
    v.IdRs = 5'(rs); v.IdRsData = 32'(rsd);
    v.IdRt = 5'(rt); v.IdRtData = 32'(rtd); v.IdImm = 32'(imm);
    return v;
  endfunction

  function automatic row_t mk(input in_t v, input int hold, input int flush,
                              input int emw, input int emrd, input int emo,
                              input int mww, input int mwrd, input int mwd,
                              input int ev, input int erw, input int emwr, input int ealu,
                              input int ea, input int eb, input int esd, input int est);
    row_t r;
    r.in = v;
    r.in.Hold = 1'(hold); r.in.Flush = 1'(flush);
    r.in.ExMemRegWrite = 1'(emw); r.in.ExMemRd = 5'(emrd); r.in.ExMemALUOut = 32'(emo);
    r.in.MemWbRegWrite = 1'(mww); r.in.MemWbRd = 5'(mwrd); r.in.MemWbData = 32'(mwd);
    r.ev = 1'(ev); r.erw = 1'(erw); r.emw = 1'(emwr); r.ealu = 4'(ealu);
    r.ea = 32'(ea); r.eb = 32'(eb); r.esd = 32'(esd); r.est = 1'(est);
    return r;
  endfunction

  task automatic apply(input in_t v);
    IdValid = v.IdValid; IdALUCtl = v.IdALUCtl; IdShamt = v.IdShamt;
    IdRsData = v.IdRsData; IdRtData = v.IdRtData; IdImm = v.IdImm;
    IdRs = v.IdRs; IdRt = v.IdRt; IdRd = v.IdRd;
    IdALUSrc = v.IdALUSrc; IdRegWrite = v.IdRegWrite; IdMemRead = v.IdMemRead;
    IdMemWrite = v.IdMemWrite; IdMemToReg = v.IdMemToReg;
    Flush = v.Flush; Hold = v.Hold;
    ExMemRegWrite = v.ExMemRegWrite; ExMemRd = v.ExMemRd; ExMemALUOut = v.ExMemALUOut;
    MemWbRegWrite = v.MemWbRegWrite; MemWbRd = v.MemWbRd; MemWbData = v.MemWbData;
  endtask

  // Value an instruction in EX actually sees for a source register.
  function automatic logic [31:0] fwd_val(input logic [4:0] r, input logic [31:0] rf,
                                          input in_t v);
    if (r == 5'd0) return rf;
    if (v.ExMemRegWrite && v.ExMemRd == r) return v.ExMemALUOut;
    if (v.MemWbRegWrite && v.MemWbRd == r) return v.MemWbData;
    return rf;
  endfunction

  function automatic logic exp_stall(input slot_t s, input in_t v);
    logic uses_rt;
    uses_rt = !v.IdALUSrc || v.IdMemWrite;
    return s.valid && s.mr && v.IdValid && !v.Hold && (s.rd != 5'd0) &&
           ((s.rd == v.IdRs) || (uses_rt && s.rd == v.IdRt));
  endfunction

  function automatic slot_t next_slot(input slot_t s, input in_t v, input logic st);
    slot_t n;
    if (v.Flush || st) begin
      n = '0;
    end else if (v.Hold) begin
      n = s;
    end else begin
      n.valid = v.IdValid;
      n.rw = v.IdRegWrite & v.IdValid; n.mr = v.IdMemRead & v.IdValid;
      n.mw = v.IdMemWrite & v.IdValid; n.m2r = v.IdMemToReg & v.IdValid;
      n.src = v.IdALUSrc & v.IdValid;
      n.alu = v.IdALUCtl; n.shamt = v.IdShamt;
      n.rsd = v.IdRsData; n.rtd = v.IdRtData; n.imm = v.IdImm;
      n.rs = v.IdRs; n.rt = v.IdRt; n.rd = v.IdRd;
    end
    return n;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.IdValid = ($urandom_range(9) < 8);
    v.IdALUCtl = 4'($urandom); v.IdShamt = 5'($urandom);
    v.IdRsData = $urandom; v.IdRtData = $urandom; v.IdImm = $urandom;
    v.IdRs = 5'($urandom_range(3)); v.IdRt = 5'($urandom_range(3));
    v.IdRd = 5'($urandom_range(3));
    v.IdALUSrc = 1'($urandom); v.IdRegWrite = 1'($urandom);
    v.IdMemRead = ($urandom_range(2) == 0); v.IdMemWrite = ($urandom_range(3) == 0);
    v.IdMemToReg = 1'($urandom);
    v.Flush = ($urandom_range(9) == 0); v.Hold = ($urandom_range(4) == 0);
    v.ExMemRegWrite = 1'($urandom); v.ExMemRd = 5'($urandom_range(3));
    v.ExMemALUOut = $urandom;
    v.MemWbRegWrite = 1'($urandom); v.MemWbRd = 5'($urandom_range(3));
    v.MemWbData = $urandom;
    return v;
  endfunction

  task automatic check_row(input int i);
    string s;
    s = $sformatf("row%0d", i);
    chk({s, " ExValid"},    32'(ExValid),    32'(tbl[i].ev));
    chk({s, " ExRegWrite"}, 32'(ExRegWrite), 32'(tbl[i].erw));
    chk({s, " ExMemWrite"}, 32'(ExMemWrite), 32'(tbl[i].emw));
    chk({s, " ALUCtl"},     32'(ALUCtl),     32'(tbl[i].ealu));
    chk({s, " A"},          A,               tbl[i].ea);
    chk({s, " B"},          B,               tbl[i].eb);
    chk({s, " StoreData"},  StoreData,       tbl[i].esd);
    chk({s, " Stall"},      32'(Stall),      32'(tbl[i].est));
  endtask

  task automatic check_model(input int c, input in_t v);
    string       s;
    logic [31:0] frs, frt;
    s   = $sformatf("rand%0d", c);
    frs = fwd_val(m.rs, m.rsd, v);
    frt = fwd_val(m.rt, m.rtd, v);
    chk({s, " ExValid"},    32'(ExValid),    32'(m.valid));
    chk({s, " ExRegWrite"}, 32'(ExRegWrite), 32'(m.rw));
    chk({s, " ExMemRead"},  32'(ExMemRead),  32'(m.mr));
    chk({s, " ExMemWrite"}, 32'(ExMemWrite), 32'(m.mw));
    chk({s, " ExMemToReg"}, 32'(ExMemToReg), 32'(m.m2r));
    chk({s, " ALUCtl"},     32'(ALUCtl),     32'(m.alu));
    chk({s, " Shamt"},      32'(Shamt),      32'(m.shamt));
    chk({s, " ExRd"},       32'(ExRd),       32'(m.rd));
    chk({s, " A"},          A,               frs);
    chk({s, " B"},          B,               m.src ? m.imm : frt);
    chk({s, " StoreData"},  StoreData,       frt);
    chk({s, " Stall"},      32'(Stall),      32'(exp_stall(m, v)));
  endtask

  initial begin
    in_t v;

    // Directed table: expected values are the outputs seen while that
    // row's inputs are applied (EX holds what the previous row captured).
    tbl[0]  = mk(rtype(ALU_ADD, 2, 5, 3, 7, 1), 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(idle(), 1, 0, 0, 0, 0,    0, 0, 0,      1, 1, 0, ALU_ADD, 5, 7, 7, 0);
    tbl[2]  = mk(idle(), 1, 0, 1, 2, 'h11, 1, 2, 'h22,   1, 1, 0, ALU_ADD, 'h11, 7, 7, 0);
    tbl[3]  = mk(idle(), 1, 0, 0, 2, 'h11, 1, 2, 'h22,   1, 1, 0, ALU_ADD, 'h22, 7, 7, 0);
    tbl[4]  = mk(idle(), 1, 0, 1, 0, 'h11, 1, 0, 'h22,   1, 1, 0, ALU_ADD, 5, 7, 7, 0);
    tbl[5]  = mk(idle(), 1, 0, 1, 3, 'h33, 0, 0, 0,      1, 1, 0, ALU_ADD, 5, 'h33, 'h33, 0);
    tbl[6]  = mk(idle(), 0, 0, 0, 0, 0,    0, 0, 0,      1, 1, 0, ALU_ADD, 5, 7, 7, 0);
    tbl[7]  = mk(lw(1, 'h100, 8, 4), 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(rtype(ALU_ADD, 4, 'h44, 5, 'h55, 6), 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, ALU_ADD, 'h100, 8, 0, 1);
    tbl[9]  = mk(rtype(ALU_ADD, 4, 'h44, 5, 'h55, 6), 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(idle(), 0, 0, 0, 0, 0, 1, 4, 'hABC,     1, 1, 0, ALU_ADD, 'hABC, 'h55, 'h55, 0);
    tbl[11] = mk(rtype(ALU_SUB, 7, 1, 8, 2, 9), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(rtype(ALU_SUB, 7, 1, 8, 2, 9), 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(sw(7, 'h70, 8, 'h80, 4), 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(lw(7, 'h70, 'hC, 10), 0, 0, 0, 0, 0, 0, 0, 0,          1, 0, 1, ALU_ADD, 'h70, 4, 'h80, 0);
    tbl[15] = mk(rtype(ALU_ADD, 10, 1, 0, 0, 12), 1, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, ALU_ADD, 'h70, 'hC, 0, 0);
    tbl[16] = mk(rtype(ALU_SUB, 3, 2, 10, 1, 12), 1, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, ALU_ADD, 'h70, 'hC, 0, 0);
    tbl[17] = mk(sw(0, 0, 10, 5, 0), 1, 0, 0, 0, 0, 0, 0, 0,            1, 1, 0, ALU_ADD, 'h70, 'hC, 0, 0);
    tbl[18] = mk(rtype(ALU_ADD, 10, 1, 0, 0, 12), 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, ALU_ADD, 'h70, 'hC, 0, 1);
    tbl[19] = mk(lw(0, 0, 'h10, 11), 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(rtype(ALU_ADD, 11, 0, 0, 0, 12), 0, 1, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, ALU_ADD, 0, 'h10, 0, 1);
    tbl[21] = mk(idle(), 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with a valid instruction presented at the inputs.
    rst = 1'b1;
    v = rtype(ALU_SUB, 2, 5, 3, 7, 1);
    apply(v);
    repeat (2) @(negedge clk);
    #1;
    chk("reset ExValid",    32'(ExValid),    32'h0);
    chk("reset ExRegWrite", 32'(ExRegWrite), 32'h0);
    chk("reset ExMemRead",  32'(ExMemRead),  32'h0);
    chk("reset ALUCtl",     32'(ALUCtl),     32'h0);
    chk("reset Shamt",      32'(Shamt),      32'h0);
    chk("reset ExRd",       32'(ExRd),       32'h0);
    chk("reset A",          A,               32'h0);
    chk("reset B",          B,               32'h0);
    chk("reset StoreData",  StoreData,       32'h0);
    chk("reset Stall",      32'(Stall),      32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post-reset ExValid",    32'(ExValid),    32'h1);
    chk("post-reset ExRegWrite", 32'(ExRegWrite), 32'h1);
    chk("post-reset ALUCtl",     32'(ALUCtl),     32'(ALU_SUB));
    chk("post-reset ExRd",       32'(ExRd),       32'h1);
    chk("post-reset A",          A,               32'h5);
    chk("post-reset B",          B,               32'h7);
    apply(idle());

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      apply(tbl[i].in);
      #1;
      check_row(i);
    end

    // The last table row was an idle capture, so EX now holds all zeros.
    m = '0;
    for (int c = 0; c < 400; c++) begin
      logic st;
      @(negedge clk);
      v = rand_in();
      apply(v);
      #1;
      check_model(c, v);
      st = exp_stall(m, v);
      m  = next_slot(m, v, st);
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    apply(lw(0, 0, 0, 5));
    @(negedge clk);
    apply(rtype(ALU_ADD, 5, 1, 0, 0, 6));
    #1;
    chk("midstall Stall before reset", 32'(Stall), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midstall Stall after reset",     32'(Stall),     32'h0);
    chk("midstall ExMemRead after reset", 32'(ExMemRead), 32'h0);
    chk("midstall ExValid after reset",   32'(ExValid),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
